mux4_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the 4:1 single-bit mux. Four requesters share the mux output. The block grants one requester at a time, drives the mux selects `s1`/`s0` from the registered owner index, and bounds each grant to `HOLD_MAX` cycles for fairness. The mux itself is instantiated inside, so consumers see `out` qualified by `valid`.

---
 rtl/mux4_rr_arbiter_pkg.sv | 20 ++
 rtl/Mux4_1_Assgn.sv | 19 +
 rtl/mux4_rr_arbiter.sv | 146 ++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// mux4_rr_arbiter_pkg
// Shared definitions for the round-robin 4:1 mux arbiter:
//   state_t      - two-state arbiter FSM encoding (idle / grant held)
//   NUM_REQ      - number of requesters sharing the mux
//   selToOneHot  - converts a 2-bit owner index into the one-hot grant vector
package mux4_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int NUM_REQ = 4;

  // Owner index -> one-hot grant; bit n set means requester n owns the mux.
  function automatic logic [3:0] selToOneHot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/Mux4_1_Assgn.sv
// Mux4_1_Assgn
// Plain 4:1 single-bit multiplexer built from a continuous assignment.
// Ports:
//   i0..i3 - data inputs
//   s0, s1 - select; {s1,s0} picks the input index
//   out    - selected data, purely combinational
module Mux4_1_Assgn (
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic s0,
  input  logic s1,
  output logic out
);

  assign out = s1 ? (s0 ? i3 : i2) : (s0 ? i1 : i0);

endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
// Round-robin arbiter that decides which of four requesters drives a shared
// 4:1 mux. Each grant lasts at most HOLD_MAX cycles; on release the search
// restarts just past the previous owner, so every requester gets its turn.
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst        - synchronous active-high reset
//   req[3:0]   - request per requester
//   i0..i3     - requester data into the mux
//   gnt[3:0]   - registered one-hot grant, zero when idle
//   s0, s1     - registered mux select, {s1,s0} = owner index
//   valid      - high while a grant is active, qualifies out
//   out        - mux output, combinational from i0..i3 and the selects
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 4,
  parameter int CW       = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       i0,
  input  logic       i1,
  input  logic       i2,
  input  logic       i3,
  output logic [3:0] gnt,
  output logic       s0,
  output logic       s1,
  output logic       valid,
  output logic       out
);

  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

  state_t        r_state;
  logic [1:0]    r_sel;
  logic [3:0]    r_gnt;
  logic          r_valid;
  logic [1:0]    r_ptr;
  logic [CW-1:0] r_cnt;

  logic [1:0]    w_start;
  logic [2:0]    w_search;
  logic          w_found;
  logic [1:0]    w_winner;
  logic          w_release;

  // Rotate the request vector so the search start sits at bit 0, take the
  // lowest set bit, then add the start back to recover the real index.
  // Result is {found, index}.
  function automatic logic [2:0] findWinner(input logic [3:0] reqs,
                                            input logic [1:0] start);
    logic [3:0] rot;
    logic [1:0] off;
    logic       found;
    rot   = 4'({reqs, reqs} >> start);
    found = 1'b0;
    off   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = 2'(k);
      end
    end
    return {found, off + start};
  endfunction

  // While a grant is held, a release re-arbitrates starting just past the
  // current owner, which leaves the owner last in line. When idle the
  // stored pointer is the starting point.
  assign w_start   = (r_state == ST_GRANT) ? (r_sel + 2'd1) : r_ptr;
  assign w_search  = findWinner(req, w_start);
  assign w_found   = w_search[2];
  assign w_winner  = w_search[1:0];
  assign w_release = !req[r_sel] || (r_cnt == CNT_LAST);

  // Arbiter FSM: all outputs are registered here so gnt, selects and valid
  // always move together on a clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sel   <= 2'd0;
      r_gnt   <= 4'b0000;
      r_valid <= 1'b0;
      r_ptr   <= 2'd0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state <= ST_GRANT;
            r_sel   <= w_winner;
            r_gnt   <= selToOneHot(w_winner);
            r_valid <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_gnt   <= 4'b0000;
            r_valid <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (!w_release) begin
            r_cnt <= r_cnt + CW'(1);
          end else begin
            r_ptr <= r_sel + 2'd1;
            // Hand straight over to the next requester when one is waiting,
            // otherwise drop to idle with the selects left on the old owner.
            if (w_found) begin
              r_sel   <= w_winner;
              r_gnt   <= selToOneHot(w_winner);
              r_valid <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_state <= ST_IDLE;
              r_gnt   <= 4'b0000;
              r_valid <= 1'b0;
              r_cnt   <= '0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= 4'b0000;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign valid = r_valid;
  assign s0    = r_sel[0];
  assign s1    = r_sel[1];

  Mux4_1_Assgn u_mux (
    .i0  (i0),
    .i1  (i1),
    .i2  (i2),
    .i3  (i3),
    .s0  (r_sel[0]),
    .s1  (r_sel[1]),
    .out (out)
  );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter
// Directed bench for the round-robin mux arbiter. One instance uses
// HOLD_MAX=4 and is driven from a table of hand-computed vectors; a second
// instance uses HOLD_MAX=2 to watch the grant rotate under full load.
module tb_mux4_rr_arbiter;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] data;
    logic [3:0] expGnt;
    logic       expValid;
    logic [1:0] expSel;
    logic       expOut;
  } vector_t;

  logic       clk;
  logic       rst4, rst2;
  logic [3:0] req4, req2;
  logic [3:0] dataIn;
  logic [3:0] gnt4, gnt2;
  logic       s0a, s1a, s0b, s1b;
  logic       valid4, valid2;
  logic       out4, out2;

  int errors;
  int checks;

  vector_t vecs[23];
  int      expOwner[10];

  mux4_rr_arbiter #(.HOLD_MAX(4), .CW(3)) dut4 (
    .clk   (clk),
    .rst   (rst4),
    .req   (req4),
    .i0    (dataIn[0]),
    .i1    (dataIn[1]),
    .i2    (dataIn[2]),
    .i3    (dataIn[3]),
    .gnt   (gnt4),
    .s0    (s0a),
    .s1    (s1a),
    .valid (valid4),
    .out   (out4)
  );

  mux4_rr_arbiter #(.HOLD_MAX(2), .CW(3)) dut2 (
    .clk   (clk),
    .rst   (rst2),
    .req   (req2),
    .i0    (dataIn[0]),
    .i1    (dataIn[1]),
    .i2    (dataIn[2]),
    .i3    (dataIn[3]),
    .gnt   (gnt2),
    .s0    (s0b),
    .s1    (s1b),
    .valid (valid2),
    .out   (out2)
  );

  // 10 ns clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives the table instance's inputs just after an edge
  task automatic applyStimulus(input logic r, input logic [3:0] rq,
                               input logic [3:0] d);
    rst4   = r;
    req4   = rq;
    dataIn = d;
  endtask

  // Compares one value and reports a mismatch with its context
  task automatic checkOutput(input string name, input int idx,
                             input logic [3:0] actual,
                             input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got %0h expected %0h",
               name, idx, actual, expected);
    end
  endtask

  // Advances one clock and leaves time for registered outputs to settle
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;

    //             rst  req      data     gnt      v     sel    out
    vecs[0]  = '{1'b1, 4'b1111, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b1};
    vecs[1]  = '{1'b1, 4'b1111, 4'b1110, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[2]  = '{1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1};
    vecs[3]  = '{1'b0, 4'b0100, 4'b1011, 4'b0100, 1'b1, 2'd2, 1'b0};
    vecs[4]  = '{1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1};
    vecs[5]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0};
    vecs[6]  = '{1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1};
    vecs[7]  = '{1'b0, 4'b0000, 4'b1011, 4'b0000, 1'b0, 2'd2, 1'b0};
    vecs[8]  = '{1'b0, 4'b0011, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b1};
    vecs[9]  = '{1'b0, 4'b0010, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b1};
    vecs[10] = '{1'b0, 4'b0000, 4'b1101, 4'b0000, 1'b0, 2'd1, 1'b0};
    vecs[11] = '{1'b0, 4'b0010, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b1};
    vecs[12] = '{1'b0, 4'b0011, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b1};
    vecs[13] = '{1'b0, 4'b0011, 4'b1101, 4'b0010, 1'b1, 2'd1, 1'b0};
    vecs[14] = '{1'b0, 4'b0011, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b1};
    vecs[15] = '{1'b0, 4'b0011, 4'b1110, 4'b0001, 1'b1, 2'd0, 1'b0};
    vecs[16] = '{1'b0, 4'b1100, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1};
    vecs[17] = '{1'b0, 4'b1100, 4'b1011, 4'b0100, 1'b1, 2'd2, 1'b0};
    vecs[18] = '{1'b0, 4'b1000, 4'b1000, 4'b1000, 1'b1, 2'd3, 1'b1};
    vecs[19] = '{1'b0, 4'b1000, 4'b0111, 4'b1000, 1'b1, 2'd3, 1'b0};
    vecs[20] = '{1'b1, 4'b1000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[21] = '{1'b0, 4'b1000, 4'b1000, 4'b1000, 1'b1, 2'd3, 1'b1};
    vecs[22] = '{1'b0, 4'b0000, 4'b0111, 4'b0000, 1'b0, 2'd3, 1'b0};

    expOwner = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

    rst2 = 1'b1;
    req2 = 4'b0000;
    applyStimulus(1'b1, 4'b1111, 4'b0000);
    #1;

    // Table-driven sequence on the HOLD_MAX=4 instance
    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].data);
      stepClock();
      checkOutput("gnt",   i, gnt4, vecs[i].expGnt);
      checkOutput("valid", i, {3'b000, valid4}, {3'b000, vecs[i].expValid});
      checkOutput("sel",   i, {2'b00, s1a, s0a}, {2'b00, vecs[i].expSel});
      checkOutput("out",   i, {3'b000, out4}, {3'b000, vecs[i].expOut});
    end

    // Selects are held at 3 while idle; out must track i3 with no clock
    dataIn = 4'b1000;
    #1;
    checkOutput("out_comb_hi", 0, {3'b000, out4}, 4'b0001);
    dataIn = 4'b0111;
    #1;
    checkOutput("out_comb_lo", 1, {3'b000, out4}, 4'b0000);

    // Full-load rotation on the HOLD_MAX=2 instance
    rst4 = 1'b1;
    req4 = 4'b0000;
    rst2 = 1'b1;
    req2 = 4'b1111;
    stepClock();
    checkOutput("rot_reset_gnt", 0, gnt2, 4'b0000);
    rst2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      stepClock();
      checkOutput("rot_gnt",   i, gnt2, 4'b0001 << expOwner[i]);
      checkOutput("rot_valid", i, {3'b000, valid2}, 4'b0001);
      checkOutput("rot_sel",   i, {2'b00, s1b, s0b}, 4'(expOwner[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
